// File: rtl/ram_sync_be.sv
// Single-port synchronous RAM with byte enables, optional post-reset zeroing sweep, READ_LAT-cycle read pipeline.
// One request per cycle once init_done is high; there is no back-pressure (req_ready=0 only in reset and during the sweep).
module ram_sync_be #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_acc;
  logic              wr_acc;
  logic              clearing;

  logic              pipe_vld [READ_LAT];
  logic [DATA_W-1:0] pipe_dat [READ_LAT];

  assign rd_acc   = req_valid & req_ready & ~req_write;
  assign wr_acc   = req_valid & req_ready & req_write;
  assign clearing = (state == ST_CLEAR);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      sweep_addr <= '0;
      req_ready  <= 1'b0;
      init_done  <= 1'b0;
    end else if (clearing) begin
      sweep_addr <= sweep_addr + 1'b1;
      if (sweep_addr == '1) begin
        state     <= ST_READY;
        req_ready <= 1'b1;
        init_done <= 1'b1;
      end
    end else begin
      req_ready <= 1'b1;
      init_done <= 1'b1;
    end
  end

  // Storage has no reset so contents survive reset when the sweep is disabled.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (clearing) begin
        mem[sweep_addr] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < NB; i++) begin
          if (req_be[i]) begin
            mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Data stages only advance behind a valid so the last stage holds the previous response.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) begin
        pipe_dat[0] <= mem[req_addr];
      end
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
    end
  end

  assign rsp_valid = pipe_vld[READ_LAT-1];
  assign rsp_rdata = pipe_dat[READ_LAT-1];

endmodule

// File: tb/tb_ram_sync_be.sv
// Three instances (lat1/clear, lat3/clear, lat2/no-clear) on one shared request bus, each checked every cycle against a behavioural model.
module tb_ram_sync_be;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rst_n;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam int CLR = (g == 2) ? 0 : 1;

    logic          rdy;
    logic          vld;
    logic          done;
    logic [DW-1:0] dat;

    ram_sync_be #(
      .DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT), .CLEAR_ON_RESET(CLR)
    ) u_dut (
      .clock(clk), .reset_n(rst_n[g]),
      .req_valid(req_valid), .req_ready(rdy), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(vld), .rsp_rdata(dat), .init_done(done)
    );

    // Model: memory array, an edge count to become ready, and a queue of responses stamped with their due edge.
    logic [DW-1:0] mm [DEPTH];
    int            wait_e = 1000;
    int            ecnt   = 0;
    bit            m_rdy  = 1'b0;
    bit            e_vld  = 1'b0;
    logic [DW-1:0] e_dat  = '0;
    int            q_due [$];
    logic [DW-1:0] q_dat [$];

    always @(posedge clk) begin
      ecnt++;
      if (!rst_n[g]) begin
        wait_e = (CLR != 0) ? DEPTH : 1;
        m_rdy  = 1'b0;
        e_vld  = 1'b0;
        e_dat  = '0;
        q_due.delete();
        q_dat.delete();
      end else begin
        if (!m_rdy) begin
          wait_e--;
          if (wait_e == 0) begin
            m_rdy = 1'b1;
            if (CLR != 0) for (int i = 0; i < DEPTH; i++) mm[i] = '0;
          end
        end else if (req_valid) begin
          if (req_write) begin
            for (int i = 0; i < NB; i++)
              if (req_be[i]) mm[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
          end else begin
            q_due.push_back(ecnt + LAT - 1);
            q_dat.push_back(mm[req_addr]);
          end
        end
        e_vld = 1'b0;
        if (q_due.size() > 0 && q_due[0] == ecnt) begin
          e_vld = 1'b1;
          e_dat = q_dat.pop_front();
          void'(q_due.pop_front());
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("u%0d req_ready", g), 32'(rdy), 32'(m_rdy));
        check($sformatf("u%0d init_done", g), 32'(done), 32'(m_rdy));
        check($sformatf("u%0d rsp_valid", g), 32'(vld), 32'(e_vld));
        check($sformatf("u%0d rsp_rdata", g), dat, e_dat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
    req_valid = v;
    req_write = w;
    req_addr  = a[AW-1:0];
    req_wdata = d;
    req_be    = be;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  initial begin
    rst_n     = 3'b000;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // Reset state
    tick();
    chk_en = 1'b1;
    check("reset ready", 32'(g_dut[0].rdy), 32'h0);
    check("reset done", 32'(g_dut[0].done), 32'h0);
    check("reset rvalid", 32'(g_dut[0].vld), 32'h0);
    check("reset rdata", g_dut[0].dat, 32'h0);
    tick();

    // No-clear instance comes up one cycle after release
    rst_n[2] = 1'b1;
    tick();
    check("noclr ready after release", 32'(g_dut[2].rdy), 32'h1);
    check("noclr done after release", 32'(g_dut[2].done), 32'h1);

    // Sweep on clearing instances; these writes land only in the no-clear one
    rst_n[1:0] = 2'b11;
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 1'b1, k, $urandom, 4'hF);
      check("sweep init_done", 32'(g_dut[0].done), 32'(k == DEPTH - 1));
      check("sweep req_ready", 32'(g_dut[1].rdy), 32'(k == DEPTH - 1));
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 1'b0, k, 32'h0, 4'h0);
      check("swept word valid", 32'(g_dut[0].vld), 32'h1);
      check("swept word zero", g_dut[0].dat, 32'h0);
    end
    idle(4);

    // Byte-enable merge
    drive(1'b1, 1'b1, 3, 32'hDEADBEEF, 4'b1111);
    check("no rsp for write", 32'(g_dut[0].vld), 32'h0);
    drive(1'b1, 1'b1, 3, 32'h000000AA, 4'b0001);
    drive(1'b1, 1'b0, 3, 32'h0, 4'h0);
    check("be merge valid", 32'(g_dut[0].vld), 32'h1);
    check("be merge data", g_dut[0].dat, 32'hDEADBEAA);

    // Write then immediate read of same address
    drive(1'b1, 1'b1, 5, 32'h12345678, 4'hF);
    check("write no rsp", 32'(g_dut[0].vld), 32'h0);
    drive(1'b1, 1'b0, 5, 32'h0, 4'h0);
    check("raw valid", 32'(g_dut[0].vld), 32'h1);
    check("raw data", g_dut[0].dat, 32'h12345678);
    idle(4);

    // READ_LAT=3 back-to-back reads
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, k, 32'h10 + k, 4'hF);
    idle(4);
    drive(1'b1, 1'b0, 0, 32'h0, 4'h0);
    check("lat3 early0", 32'(g_dut[1].vld), 32'h0);
    drive(1'b1, 1'b0, 1, 32'h0, 4'h0);
    check("lat3 early1", 32'(g_dut[1].vld), 32'h0);
    drive(1'b1, 1'b0, 2, 32'h0, 4'h0);
    check("lat3 rsp0 valid", 32'(g_dut[1].vld), 32'h1);
    check("lat3 rsp0 data", g_dut[1].dat, 32'h10);
    idle(1);
    check("lat3 rsp1 data", g_dut[1].dat, 32'h11);
    idle(1);
    check("lat3 rsp2 valid", 32'(g_dut[1].vld), 32'h1);
    check("lat3 rsp2 data", g_dut[1].dat, 32'h12);
    idle(1);
    check("lat3 done valid", 32'(g_dut[1].vld), 32'h0);
    check("lat3 hold data", g_dut[1].dat, 32'h12);
    idle(4);

    // Reset flushes an in-flight read
    drive(1'b1, 1'b0, 5, 32'h0, 4'h0);
    rst_n[1]  = 1'b0;
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("flushed read", 32'(g_dut[1].vld), 32'h0);
    end
    rst_n[1] = 1'b1;
    idle(9);
    // Sweep now at address 9; reset restarts it
    rst_n[1] = 1'b0;
    idle(1);
    rst_n[1] = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      idle(1);
      check("restart sweep done", 32'(g_dut[1].done), 32'(k == DEPTH - 1));
    end
    idle(2);

    // Contents survive reset without the sweep
    drive(1'b1, 1'b1, 7, 32'hCAFEF00D, 4'hF);
    rst_n[2] = 1'b0;
    idle(1);
    check("noclr reset ready", 32'(g_dut[2].rdy), 32'h0);
    check("noclr reset done", 32'(g_dut[2].done), 32'h0);
    idle(1);
    rst_n[2] = 1'b1;
    idle(1);
    check("noclr ready again", 32'(g_dut[2].rdy), 32'h1);
    drive(1'b1, 1'b0, 7, 32'h0, 4'h0);
    check("noclr lat2 early", 32'(g_dut[2].vld), 32'h0);
    idle(1);
    check("noclr kept valid", 32'(g_dut[2].vld), 32'h1);
    check("noclr kept data", g_dut[2].dat, 32'hCAFEF00D);
    idle(2);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
